// File: rtl/sd_mode_ctrl_if.sv
// Scan doubler mode controller bus: sync/user inputs toward the controller,
// applied configuration and measurements back out.
interface sd_mode_ctrl_if #(
    parameter int HCNT_W = 12,
    parameter int VCNT_W = 10
);
    logic              hs_in;
    logic              vs_in;
    logic              user_bypass;
    logic [1:0]        user_scanlines;
    logic              bypass;
    logic              ce_divider;
    logic [1:0]        scanlines;
    logic              locked;
    logic              mode_pal;
    logic [HCNT_W-1:0] line_len;
    logic [VCNT_W-1:0] frame_lines;
    logic              mode_change;

    modport master (
        output hs_in, vs_in, user_bypass, user_scanlines,
        input  bypass, ce_divider, scanlines, locked, mode_pal,
               line_len, frame_lines, mode_change
    );

    modport slave (
        input  hs_in, vs_in, user_bypass, user_scanlines,
        output bypass, ce_divider, scanlines, locked, mode_pal,
               line_len, frame_lines, mode_change
    );
endinterface

// File: rtl/sd_mode_ctrl.sv
// Scan doubler mode controller: measures line length / lines per frame,
// locks onto stable timing and applies bypass/ce_divider/scanlines only at
// frame boundaries. Optional macro SD_SYNC_WATCHDOG_EN adds a sync-loss
// watchdog that drops lock without waiting for the next vsync.
module sd_mode_ctrl #(
    parameter int HCNT_W        = 12,
    parameter int VCNT_W        = 10,
    parameter int STABLE_FRAMES = 4,
    parameter int PAL_MIN_LINES = 288,
    parameter int DIV_THRESH    = 1536
) (
    input  logic          clk_sys,
    input  logic          reset,
    sd_mode_ctrl_if.slave sd
);
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam logic [HCNT_W-1:0] HMAX     = '1;
    localparam logic [VCNT_W-1:0] VMAX     = '1;
    localparam logic [VCNT_W-1:0] VLO      = VCNT_W'(200);
    localparam logic [VCNT_W-1:0] VHI      = VCNT_W'(400);
    localparam logic [VCNT_W-1:0] PAL_T    = VCNT_W'(PAL_MIN_LINES);
    localparam logic [HCNT_W-1:0] DIV_T    = HCNT_W'(DIV_THRESH);
    localparam logic [SW-1:0]     STABLE_T = SW'(STABLE_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

    logic [2:0]        hs_q, vs_q;     // [0],[1] synchronizer, [2] delay
    logic              hs_fall, vs_fall;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d, prev_ll_q, prev_ll_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d, vcnt_inc, frame_lines_q, frame_lines_d;
    logic              seen_vs_q;
    state_t            state_q, state_d;
    logic [SW-1:0]     stable_q, stable_d;
    logic              apply_q, apply_d;
    logic              frame_valid, frame_match, wd_fire;
    logic [VCNT_W:0]   fl_a, fl_b, fl_dist;
    logic [HCNT_W:0]   ll_a, ll_b, ll_dist;
    logic              bypass_q, ce_q, pal_q, mc_q;
    logic [1:0]        sl_q;
    logic              bypass_n, ce_n, pal_n;
    logic [1:0]        sl_n;

    assign hs_fall = hs_q[2] & ~hs_q[1];
    assign vs_fall = vs_q[2] & ~vs_q[1];

    // Sync inputs into clk_sys and keep one delayed copy for edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            hs_q <= {hs_q[1:0], sd.hs_in};
            vs_q <= {vs_q[1:0], sd.vs_in};
        end
    end

    // Line/frame measurement; a coincident vs fall captures vcnt before the hs count
    always_comb begin
        hcnt_d        = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + HCNT_W'(1);
        vcnt_inc      = (vcnt_q == VMAX) ? vcnt_q : vcnt_q + VCNT_W'(1);
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        prev_ll_d     = prev_ll_q;
        if (hs_fall) begin
            line_len_d = hcnt_q;
            hcnt_d     = HCNT_W'(1);
            vcnt_d     = vcnt_inc;
        end
        if (vs_fall) begin
            frame_lines_d = vcnt_q;
            prev_ll_d     = line_len_d;
            vcnt_d        = hs_fall ? VCNT_W'(1) : '0;
        end
    end

    // Frame qualification against the previous frame's measurements
    always_comb begin
        fl_a        = {1'b0, vcnt_q};
        fl_b        = {1'b0, frame_lines_q};
        fl_dist     = (fl_a >= fl_b) ? fl_a - fl_b : fl_b - fl_a;
        ll_a        = {1'b0, line_len_d};
        ll_b        = {1'b0, prev_ll_q};
        ll_dist     = (ll_a >= ll_b) ? ll_a - ll_b : ll_b - ll_a;
        frame_match = (fl_dist <= (VCNT_W+1)'(1)) && (ll_dist <= (HCNT_W+1)'(2));
        // the first vsync after reset closes a partial frame
        frame_valid = seen_vs_q && (vcnt_q >= VLO) && (vcnt_q <= VHI) &&
                      (line_len_d != '0) && (line_len_d != HMAX);
    end

`ifdef SD_SYNC_WATCHDOG_EN
    logic [HCNT_W-1:0] wd_q, wd_d;

    // Watchdog fires once on the transition into saturation (no hsync / no vsync)
    always_comb begin
        wd_d    = hs_fall ? '0 : ((wd_q == HMAX) ? wd_q : wd_q + HCNT_W'(1));
        wd_fire = ((wd_q != HMAX) && (wd_d == HMAX)) ||
                  ((vcnt_q != VMAX) && (vcnt_d == VMAX));
    end

    // Watchdog counter register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Lock FSM next state, evaluated on vs fall (or watchdog loss of sync)
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        apply_d  = 1'b0;
        if (vs_fall) begin
            apply_d = 1'b1;
            case (state_q)
                UNLOCKED: if (frame_valid) begin
                    state_d  = CHECK;
                    stable_d = SW'(1);
                end
                CHECK: if (frame_match) begin
                    stable_d = stable_q + SW'(1);
                    if (stable_d >= STABLE_T) state_d = LOCKED;
                end else begin
                    state_d  = UNLOCKED;
                    stable_d = '0;
                end
                LOCKED: if (!frame_match) begin
                    state_d  = UNLOCKED;
                    stable_d = '0;
                end
                default: begin
                    state_d  = UNLOCKED;
                    stable_d = '0;
                end
            endcase
        end
        if (wd_fire) begin
            state_d  = UNLOCKED;
            stable_d = '0;
            apply_d  = 1'b1;
        end
    end

    // Measurement and FSM state registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            prev_ll_q     <= '0;
            seen_vs_q     <= 1'b0;
            state_q       <= UNLOCKED;
            stable_q      <= '0;
            apply_q       <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            prev_ll_q     <= prev_ll_d;
            seen_vs_q     <= seen_vs_q | vs_fall;
            state_q       <= state_d;
            stable_q      <= stable_d;
            apply_q       <= apply_d;
        end
    end

    // Configuration to apply, from the freshly updated lock state and measurements
    always_comb begin
        bypass_n = sd.user_bypass | (state_q != LOCKED);
        sl_n     = bypass_n ? 2'b00 : sd.user_scanlines;
        ce_n     = (line_len_q >= DIV_T) ? 1'b0 : 1'b1;
        pal_n    = (frame_lines_q >= PAL_T);
    end

    // Applied outputs change only in the apply cycle; mode_change flags any change
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bypass_q <= 1'b1;
            ce_q     <= 1'b0;
            sl_q     <= 2'b00;
            pal_q    <= 1'b0;
            mc_q     <= 1'b0;
        end else if (apply_q) begin
            bypass_q <= bypass_n;
            ce_q     <= ce_n;
            sl_q     <= sl_n;
            pal_q    <= pal_n;
            mc_q     <= (bypass_n != bypass_q) || (ce_n != ce_q) ||
                        (sl_n != sl_q) || (pal_n != pal_q);
        end else begin
            mc_q     <= 1'b0;
        end
    end

    assign sd.bypass      = bypass_q;
    assign sd.ce_divider  = ce_q;
    assign sd.scanlines   = sl_q;
    assign sd.mode_pal    = pal_q;
    assign sd.mode_change = mc_q;
    assign sd.locked      = (state_q == LOCKED);
    assign sd.line_len    = line_len_q;
    assign sd.frame_lines = frame_lines_q;
endmodule

// File: tb/tb_sd_mode_ctrl.sv
// Directed bench for sd_mode_ctrl. Line lengths are shortened (PAL 6, NTSC 3
// cycles/line, DIV_THRESH=5) so whole frames stay cheap to simulate.
module tb_sd_mode_ctrl;
    logic clk_sys = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int   mc_cnt = 0;
    int   mc_base;

    always #5 clk_sys = ~clk_sys;

    sd_mode_ctrl_if sd ();

    sd_mode_ctrl #(.DIV_THRESH(5)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sd      (sd)
    );

    // count mode_change pulses
    always @(negedge clk_sys) if (sd.mode_change) mc_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // lines [first, first+n); line 0 carries the vsync fall with its hsync fall
    task automatic part(input int first, input int n, input int ll);
        for (int l = first; l < first + n; l++)
            for (int c = 0; c < ll; c++) begin
                @(negedge clk_sys);
                sd.hs_in = (c < 2) ? 1'b0 : 1'b1;
                sd.vs_in = (l == 0 && c < 2) ? 1'b0 : 1'b1;
            end
    endtask

    task automatic frame(input int n, input int ll);
        part(0, n, ll);
    endtask

    initial begin
        reset = 1'b1;
        sd.hs_in = 1'b1; sd.vs_in = 1'b1;
        sd.user_bypass = 1'b0; sd.user_scanlines = 2'b10;
        repeat (3) @(negedge clk_sys);
        chk("rst_bypass", 32'(sd.bypass), 1);
        chk("rst_locked", 32'(sd.locked), 0);
        chk("rst_ce",     32'(sd.ce_divider), 0);
        chk("rst_sl",     32'(sd.scanlines), 0);
        chk("rst_pal",    32'(sd.mode_pal), 0);
        chk("rst_ll",     32'(sd.line_len), 0);
        chk("rst_fl",     32'(sd.frame_lines), 0);
        chk("rst_mc",     32'(sd.mode_change), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);

        // PAL lock: vs #2 -> CHECK, lock at vs #5
        repeat (4) frame(312, 6);
        chk("pal_prelock", 32'(sd.locked), 0);
        chk("pal_prebyp",  32'(sd.bypass), 1);
        mc_base = mc_cnt;
        frame(312, 6);
        chk("pal_lock",  32'(sd.locked), 1);
        chk("pal_byp",   32'(sd.bypass), 0);
        chk("pal_sl",    32'(sd.scanlines), 2);
        chk("pal_ce",    32'(sd.ce_divider), 0);
        chk("pal_mode",  32'(sd.mode_pal), 1);
        chk("pal_fl",    32'(sd.frame_lines), 312);
        chk("pal_ll",    32'(sd.line_len), 6);
        chk("pal_mc",    32'(mc_cnt - mc_base), 1);
        frame(312, 6);
        chk("pal_hold",  32'(sd.locked), 1);

        // scanline change mid-frame takes effect only at next vs fall
        mc_base = mc_cnt;
        part(0, 156, 6);
        sd.user_scanlines = 2'b11;
        part(156, 156, 6);
        chk("sl_mid",    32'(sd.scanlines), 2);
        chk("sl_mid_mc", 32'(mc_cnt - mc_base), 0);
        frame(312, 6);
        chk("sl_new",    32'(sd.scanlines), 3);
        chk("sl_new_mc", 32'(mc_cnt - mc_base), 1);

        // jitter within tolerance keeps lock
        mc_base = mc_cnt;
        frame(313, 7);
        frame(312, 5);
        frame(313, 7);
        frame(312, 6);
        chk("jit_lock", 32'(sd.locked), 1);
        chk("jit_mc",   32'(mc_cnt - mc_base), 0);
        chk("jit_fl",   32'(sd.frame_lines), 313);

        // one short frame drops lock, relock 4 frames later
        frame(280, 6);
        chk("short_pre", 32'(sd.locked), 1);
        mc_base = mc_cnt;
        frame(312, 6);
        chk("short_lock", 32'(sd.locked), 0);
        chk("short_byp",  32'(sd.bypass), 1);
        chk("short_sl",   32'(sd.scanlines), 0);
        chk("short_pal",  32'(sd.mode_pal), 0);
        chk("short_fl",   32'(sd.frame_lines), 280);
        chk("short_mc",   32'(mc_cnt - mc_base), 1);
        repeat (3) frame(312, 6);
        chk("relock_pre", 32'(sd.locked), 0);
        frame(312, 6);
        chk("relock",     32'(sd.locked), 1);
        chk("relock_byp", 32'(sd.bypass), 0);
        chk("relock_sl",  32'(sd.scanlines), 3);
        chk("relock_pal", 32'(sd.mode_pal), 1);

        // switch to NTSC timing
        frame(263, 3);
        frame(263, 3);
        chk("ntsc_drop", 32'(sd.locked), 0);
        repeat (4) frame(263, 3);
        chk("ntsc_lock", 32'(sd.locked), 1);
        chk("ntsc_pal",  32'(sd.mode_pal), 0);
        chk("ntsc_ce",   32'(sd.ce_divider), 1);
        chk("ntsc_fl",   32'(sd.frame_lines), 263);
        chk("ntsc_ll",   32'(sd.line_len), 3);
        chk("ntsc_byp",  32'(sd.bypass), 0);

        // hsync/vsync stop long enough to saturate the line counter
        mc_base = mc_cnt;
        repeat (4150) @(negedge clk_sys);
`ifdef SD_SYNC_WATCHDOG_EN
        chk("wd_lock", 32'(sd.locked), 0);
        chk("wd_byp",  32'(sd.bypass), 1);
        chk("wd_mc",   32'(mc_cnt - mc_base), 1);
`else
        chk("nosync_lock", 32'(sd.locked), 1);
        chk("nosync_byp",  32'(sd.bypass), 0);
        chk("nosync_mc",   32'(mc_cnt - mc_base), 0);
`endif

        // asynchronous reset mid-frame
        part(1, 50, 3);
        reset = 1'b1;
        #1;
        chk("arst_bypass", 32'(sd.bypass), 1);
        chk("arst_locked", 32'(sd.locked), 0);
        chk("arst_ce",     32'(sd.ce_divider), 0);
        chk("arst_sl",     32'(sd.scanlines), 0);
        chk("arst_pal",    32'(sd.mode_pal), 0);
        chk("arst_ll",     32'(sd.line_len), 0);
        chk("arst_fl",     32'(sd.frame_lines), 0);
        sd.hs_in = 1'b1; sd.vs_in = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

        // partial first frame after reset must not count towards lock
        part(1, 300, 3);
        repeat (4) frame(300, 3);
        chk("partial_nolock", 32'(sd.locked), 0);
        frame(300, 3);
        chk("partial_lock", 32'(sd.locked), 1);
        chk("partial_pal",  32'(sd.mode_pal), 1);
        chk("partial_ce",   32'(sd.ce_divider), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sd_mode_ctrl.md
Name: sd_mode_ctrl

Overview:
- Configuration and sequencing controller for the scan doubler line-buffer datapath.
- Measures incoming sync timing in clk_sys cycles: line length between hsync falling edges, and lines per frame between vsync falling edges.
- Runs a lock state machine and derives the PAL/NTSC flag and the pixel-clock divider select.
- Drives the scan doubler's bypass, ce_divider and scanlines inputs. Changes are applied glitch-free, only at frame boundaries.

Parameters:
- HCNT_W, 12, width of line-length counter (clk_sys cycles per line); saturates at all-ones.
- VCNT_W, 10, width of line-per-frame counter; saturates at all-ones.
- STABLE_FRAMES, 4, consecutive matching frames required to enter LOCKED.
- PAL_MIN_LINES, 288, frame_lines >= this value means PAL, else NTSC.
- DIV_THRESH, 1536, line_len >= this selects ce_divider=0 (divide-by-4), else 1 (divide-by-2).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hs_in  in  1  horizontal sync, active low; falling edge = line start.
- vs_in  in  1  vertical sync, active low; falling edge = frame start.
- user_bypass  in  1  user request for bypass (15 kHz passthrough).
- user_scanlines  in  2  user scanline level (00 none, 01 25%, 10 50%, 11 75%).
- bypass  out  1  to scan doubler.
- ce_divider  out  1  to scan doubler.
- scanlines  out  2  to scan doubler.
- locked  out  1  timing stable.
- mode_pal  out  1  1 = PAL frame length detected.
- line_len  out  HCNT_W  last measured line length.
- frame_lines  out  VCNT_W  last measured line count.
- mode_change  out  1  one-cycle pulse when any applied output value changes.

Behaviour:
- Reset values: bypass=1, ce_divider=0, scanlines=0, locked=0, mode_pal=0, line_len=0, frame_lines=0, mode_change=0. All counters and state are 0; FSM is in UNLOCKED.
- Edge detection: hs_in and vs_in each pass through a 2-flop synchronizer plus one delay flop. Edges are detected on the synchronized pair, so edge-to-action latency is 3 cycles.
- Line counter hcnt:
  - Increments every cycle, saturating at all-ones.
  - On hs fall: line_len<=hcnt, hcnt<=1.
- Line count vcnt:
  - Increments on each hs fall, saturating.
  - On vs fall: frame_lines<=vcnt, vcnt<=0.
  - When hs fall and vs fall occur in the same cycle, the vs fall is processed first, then vcnt<=1.
- Frame match: frame_lines differs from the previous frame by at most 1, AND line_len differs from the previous frame's captured line_len by at most 2. Comparison uses unsigned subtraction with width+1 bits.
- FSM, evaluated on each vs fall:
  - UNLOCKED: if the frame is valid (frame_lines in 200..400 and line_len nonzero and not saturated), go to CHECK with stable_cnt=1. Otherwise stay.
  - CHECK: on match, stable_cnt++. When stable_cnt reaches STABLE_FRAMES, go to LOCKED and set locked=1. On mismatch, go to UNLOCKED with stable_cnt=0.
  - LOCKED: on mismatch, go to UNLOCKED and set locked=0 in the same cycle.
- Applied configuration:
  - Computed in the cycle after the vs fall that updates the FSM.
  - bypass = user_bypass | ~locked_next.
  - scanlines = bypass ? 0 : user_scanlines.
  - ce_divider = (line_len >= DIV_THRESH) ? 0 : 1.
  - mode_pal = (frame_lines >= PAL_MIN_LINES).
  - Outputs change only in that cycle; user inputs changing mid-frame have no effect until the next vs fall.
- mode_change pulses in the apply cycle if any of bypass, ce_divider, scanlines or mode_pal differ from their previous values.
- Reset mid-frame returns everything to reset values immediately (asynchronous). The first frame after reset release is partial: line_len/frame_lines are captured but treated as invalid, and the FSM remains in UNLOCKED.

Optional Feature:
- Macro: SD_SYNC_WATCHDOG_EN.
- Defined: a watchdog counter is cleared on each hs fall.
  - If it reaches 2^HCNT_W - 1 (no hsync), the FSM is forced to UNLOCKED immediately, without waiting for vsync.
  - locked=0 and bypass=1 are applied on the next cycle, and mode_change pulses.
  - Loss of vsync for more than 1023 lines (vcnt saturated) has the same effect.
- Not defined: loss of sync is detected only through frame mismatch at the next vs fall. A permanently absent vsync therefore keeps the last state.

Test Plan:
- Reset, then feed 6 PAL frames (312 lines, 2048 cycles/line), user_bypass=0, user_scanlines=10 -> locked=1 applied at the 5th vs fall, bypass=0, scanlines=2, ce_divider=0, mode_pal=1, one mode_change pulse.
- NTSC frames (263 lines, 1024 cycles/line) -> mode_pal=0, ce_divider=1, frame_lines=263, line_len=1024 after lock.
- Locked PAL, then one frame of 280 lines -> locked=0 and bypass=1 at that vs fall; relock 4 frames later.
- Locked, toggle user_scanlines 10->11 mid-frame -> scanlines stays 2 until the next vs fall, then becomes 3 with one mode_change pulse.
- Jitter: line_len alternating 2047/2049 and frame_lines 312/313 -> lock maintained.
- SD_SYNC_WATCHDOG_EN defined, locked, stop hs_in for 4100 cycles -> locked=0, bypass=1 before the next vs fall. Assert reset mid-frame -> all outputs at reset values in the same cycle.
